// File: rtl/riscv_soc_pkg.sv
// Shared types for the riscv kernel controller:
// FSM state encoding and the ap_ctrl status bit layout.
package riscv_soc_pkg;

   typedef enum logic [2:0] {
      S_IDLE        = 3'd0,
      S_RESET_CORES = 3'd1,
      S_RUN         = 3'd2,
      S_DRAIN       = 3'd3,
      S_DONE        = 3'd4
   } kctrl_state_e;

   localparam int AP_DONE_BIT  = 0;
   localparam int AP_IDLE_BIT  = 1;
   localparam int AP_READY_BIT = 2;
   localparam int AP_STAT_W    = 3;

   localparam int WAIT_W = 16;

   function automatic logic [AP_STAT_W-1:0] ap_stat(
      input logic idle,
      input logic done
   );
      logic [AP_STAT_W-1:0] s;
      s               = '0;
      s[AP_IDLE_BIT]  = idle;
      s[AP_DONE_BIT]  = done;
      s[AP_READY_BIT] = done;
      return s;
   endfunction

endpackage

// File: rtl/kernel_halt_detect.sv
// Per-core END_PC compare with a sticky halted flag,
// cleared only when a new run is accepted.
module kernel_halt_detect #(
   parameter int             PCW    = 32,
   parameter logic [PCW-1:0] END_PC = 'h0000_00A0
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   input  logic           clr_i,
   input  logic           en_i,
   input  logic [PCW-1:0] pc_i,
   output logic           halted_d_o,
   output logic           halted_q_o
);

   logic halted_q;

   assign halted_d_o = halted_q | (en_i & (pc_i == END_PC));
   assign halted_q_o = halted_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         halted_q <= 1'b0;
      end else if (clr_i) begin
         halted_q <= 1'b0;
      end else begin
         halted_q <= halted_d_o;
      end
   end

endmodule

// File: rtl/riscv_kernel_ctrl.sv
// ap_ctrl_hs run controller for a set of riscv_kernel cores:
// reset pulse, run until all halt or timeout, drain, done.
module riscv_kernel_ctrl
   import riscv_soc_pkg::*;
#(
   parameter int             NUM_CORES    = 4,
   parameter int             PCW          = 32,
   parameter logic [PCW-1:0] END_PC       = 'h0000_00A0,
   parameter int             DRAIN_CYCLES = 4,
   parameter int             RST_CYCLES   = 2
) (
   input  logic                     ap_clk,
   input  logic                     ap_rst_n,
   input  logic                     ap_start,
   input  logic [NUM_CORES-1:0]     core_mask,
   input  logic [31:0]              timeout_limit,
   input  logic [NUM_CORES*PCW-1:0] core_pc,
   output logic [NUM_CORES-1:0]     core_rst,
   output logic                     ap_idle,
   output logic                     ap_done,
   output logic                     ap_ready,
   output logic [NUM_CORES-1:0]     halted,
   output logic [31:0]              cycle_count,
   output logic                     timeout
);

   kctrl_state_e          state_q;
   logic [1:0]            rst_sync_q;
   logic                  rst_s_n;
   logic [AP_STAT_W-1:0]  stat_q;
   logic [NUM_CORES-1:0]  core_rst_q;
   logic [NUM_CORES-1:0]  mask_q;
   logic [NUM_CORES-1:0]  halted_d;
   logic [NUM_CORES-1:0]  halted_q;
   logic [31:0]           limit_q;
   logic [31:0]           cnt_q;
   logic [31:0]           cnt_inc;
   logic                  timeout_q;
   logic [WAIT_W-1:0]     wait_q;
   logic                  start_acc;
   logic                  in_run;
   logic                  all_halt;
   logic                  limit_hit;

   // Assert asynchronously, release two edges later.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         rst_sync_q <= '0;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   assign rst_s_n   = rst_sync_q[1];
   assign start_acc = (state_q == S_IDLE) & ap_start;
   assign in_run    = (state_q == S_RUN);
   assign all_halt  = &(halted_d | ~mask_q);
   assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + 32'd1;
   assign limit_hit = (limit_q != '0) && (cnt_q + 32'd1 == limit_q);

   for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
      kernel_halt_detect #(
         .PCW    (PCW),
         .END_PC (END_PC)
      ) u_det (
         .clk_i      (ap_clk),
         .rst_ni     (rst_s_n),
         .clr_i      (start_acc),
         .en_i       (in_run & mask_q[i]),
         .pc_i       (core_pc[i*PCW +: PCW]),
         .halted_d_o (halted_d[i]),
         .halted_q_o (halted_q[i])
      );
   end

   always_ff @(posedge ap_clk or negedge rst_s_n) begin
      if (!rst_s_n) begin
         state_q    <= S_IDLE;
         stat_q     <= ap_stat(1'b1, 1'b0);
         core_rst_q <= '1;
         mask_q     <= '0;
         limit_q    <= '0;
         cnt_q      <= '0;
         timeout_q  <= 1'b0;
         wait_q     <= '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (ap_start) begin
                  state_q   <= S_RESET_CORES;
                  stat_q    <= ap_stat(1'b0, 1'b0);
                  mask_q    <= core_mask;
                  limit_q   <= timeout_limit;
                  cnt_q     <= '0;
                  timeout_q <= 1'b0;
                  wait_q    <= WAIT_W'(RST_CYCLES);
               end
            end
            S_RESET_CORES: begin
               if (wait_q == '0) begin
                  state_q    <= S_RUN;
                  core_rst_q <= ~mask_q;
               end else begin
                  wait_q <= wait_q - WAIT_W'(1);
               end
            end
            S_RUN: begin
               cnt_q <= cnt_inc;
               // A halt completing on the limit cycle is not a timeout.
               if (all_halt || limit_hit) begin
                  state_q   <= S_DRAIN;
                  timeout_q <= ~all_halt;
                  wait_q    <= WAIT_W'(DRAIN_CYCLES);
               end
            end
            S_DRAIN: begin
               if (wait_q <= WAIT_W'(1)) begin
                  state_q    <= S_DONE;
                  stat_q     <= ap_stat(1'b0, 1'b1);
                  core_rst_q <= '1;
               end else begin
                  wait_q <= wait_q - WAIT_W'(1);
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               stat_q  <= ap_stat(1'b1, 1'b0);
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign core_rst    = core_rst_q;
   assign ap_idle     = stat_q[AP_IDLE_BIT];
   assign ap_done     = stat_q[AP_DONE_BIT];
   assign ap_ready    = stat_q[AP_READY_BIT];
   assign halted      = halted_q;
   assign cycle_count = cnt_q;
   assign timeout     = timeout_q;

endmodule

// File: tb/tb_riscv_kernel_ctrl.sv
// Bench for riscv_kernel_ctrl: directed run table, random runs
// against a run-length model, and async reset / sync corners.
module tb_riscv_kernel_ctrl;

   localparam int          NC    = 4;
   localparam int          PCW   = 32;
   localparam int          RSTC  = 2;
   localparam int          DRC   = 4;
   localparam logic [31:0] ENDPC = 32'h0000_00A0;
   localparam int          INF   = 1 << 30;

   typedef struct packed {
      logic [3:0]       mask;
      logic [31:0]      lim;
      logic [3:0][15:0] ht;
      logic             hold;
      logic [31:0]      cc;
      logic             to;
      logic [3:0]       h;
   } vec_t;

   logic              clk   = 1'b0;
   logic              rst_n = 1'b1;
   logic              start = 1'b0;
   logic [NC-1:0]     mask  = '0;
   logic [31:0]       lim   = '0;
   logic [NC*PCW-1:0] pc    = '0;
   logic [NC-1:0]     core_rst;
   logic              ap_idle;
   logic              ap_done;
   logic              ap_ready;
   logic [NC-1:0]     halted;
   logic [31:0]       cycle_count;
   logic              timeout;

   int errs   = 0;
   int checks = 0;

   vec_t tbl [9];

   always #5 clk = ~clk;

   riscv_kernel_ctrl #(
      .NUM_CORES    (NC),
      .PCW          (PCW),
      .END_PC       (ENDPC),
      .DRAIN_CYCLES (DRC),
      .RST_CYCLES   (RSTC)
   ) dut (
      .ap_clk        (clk),
      .ap_rst_n      (rst_n),
      .ap_start      (start),
      .core_mask     (mask),
      .timeout_limit (lim),
      .core_pc       (pc),
      .core_rst      (core_rst),
      .ap_idle       (ap_idle),
      .ap_done       (ap_done),
      .ap_ready      (ap_ready),
      .halted        (halted),
      .cycle_count   (cycle_count),
      .timeout       (timeout)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [3:0] er,
                          input logic ei, input logic ed,
                          input logic [3:0] eh, input logic [31:0] ec,
                          input logic et);
      chk({tag, ".core_rst"}, 32'(core_rst), 32'(er));
      chk({tag, ".idle"},     32'(ap_idle),  32'(ei));
      chk({tag, ".done"},     32'(ap_done),  32'(ed));
      chk({tag, ".ready"},    32'(ap_ready), 32'(ed));
      chk({tag, ".halted"},   32'(halted),   32'(eh));
      chk({tag, ".cycles"},   cycle_count,   ec);
      chk({tag, ".timeout"},  32'(timeout),  32'(et));
   endtask

   function automatic logic [PCW-1:0] pcv(input logic at_end);
      return at_end ? ENDPC : ENDPC + 32'(4 * $urandom_range(1, 64));
   endfunction

   // Cores halted once j RUN cycles have completed.
   function automatic logic [3:0] hat(input vec_t v, input int j);
      logic [3:0] r = '0;
      for (int i = 0; i < NC; i++)
         r[i] = v.mask[i] && v.ht[i] != 0 && int'(v.ht[i]) <= j;
      return r;
   endfunction

   // Run length is the earlier of last masked halt and the limit.
   function automatic vec_t model(input vec_t vin);
      vec_t v = vin;
      int th = 1;
      int tt;
      int len;
      for (int i = 0; i < NC; i++) begin
         int t;
         t = (v.ht[i] == 0) ? INF : int'(v.ht[i]);
         if (v.mask[i] && t > th) th = t;
      end
      tt   = (v.lim == 0) ? INF : int'(v.lim);
      len  = (th <= tt) ? th : tt;
      v.to = (tt < th);
      v.cc = 32'(len);
      v.h  = hat(v, len);
      return v;
   endfunction

   task automatic hard_reset();
      @(negedge clk);
      rst_n = 1'b0;
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic run(input int id, input vec_t v);
      int L;
      int R;
      int last;
      logic [3:0]  er;
      logic [3:0]  eh;
      logic        ei;
      logic        ed;
      logic        et;
      logic [31:0] ec;
      L    = int'(v.cc);
      R    = 1 + RSTC;
      last = R + L + DRC + 1;
      mask  = v.mask;
      lim   = v.lim;
      start = 1'b1;
      for (int i = 0; i < NC; i++) pc[i*PCW +: PCW] = pcv(1'b0);
      @(posedge clk);
      for (int e = 0; e <= last; e++) begin
         @(negedge clk);
         if (!v.hold) start = 1'b0;
         er = '1; ei = 1'b0; ed = 1'b0; et = 1'b0; ec = '0; eh = '0;
         if (e >= R && e < R + L) begin
            er = ~v.mask;
            ec = 32'(e - R);
            eh = hat(v, e - R);
         end else if (e >= R + L) begin
            ec = v.cc;
            et = v.to;
            eh = v.h;
            if (e < R + L + DRC) er = ~v.mask;
            else if (e == R + L + DRC) ed = 1'b1;
            else ei = 1'b1;
         end
         chk_all($sformatf("run%0d@%0d", id, e), er, ei, ed, eh, ec, et);
         for (int i = 0; i < NC; i++) begin
            if (e < R)
               pc[i*PCW +: PCW] = pcv(1'b1);
            else if (e < R + L && v.mask[i])
               pc[i*PCW +: PCW] = pcv(v.ht[i] != 0 &&
                                      int'(v.ht[i]) <= e - R + 1);
            else
               pc[i*PCW +: PCW] = pcv(1'($urandom_range(0, 1)));
         end
      end
      if (ap_idle !== 1'b1) hard_reset();
   endtask

   initial begin
      vec_t v;
      tbl[0] = '{mask:4'hF, lim:32'd0, ht:{16'd40, 16'd30, 16'd20, 16'd10},
                 hold:1'b1, cc:32'd40, to:1'b0, h:4'hF};
      tbl[1] = '{mask:4'hF, lim:32'd0, ht:{16'd40, 16'd30, 16'd20, 16'd10},
                 hold:1'b0, cc:32'd40, to:1'b0, h:4'hF};
      tbl[2] = '{mask:4'h5, lim:32'd0, ht:{16'd0, 16'd25, 16'd0, 16'd15},
                 hold:1'b0, cc:32'd25, to:1'b0, h:4'h5};
      tbl[3] = '{mask:4'hF, lim:32'd100, ht:'0,
                 hold:1'b0, cc:32'd100, to:1'b1, h:4'h0};
      tbl[4] = '{mask:4'hF, lim:32'd30, ht:{16'd12, 16'd10, 16'd5, 16'd30},
                 hold:1'b0, cc:32'd30, to:1'b0, h:4'hF};
      tbl[5] = '{mask:4'h0, lim:32'd0, ht:'0,
                 hold:1'b0, cc:32'd1, to:1'b0, h:4'h0};
      tbl[6] = '{mask:4'h0, lim:32'd1, ht:'0,
                 hold:1'b0, cc:32'd1, to:1'b0, h:4'h0};
      tbl[7] = '{mask:4'hF, lim:32'd20, ht:{16'd0, 16'd20, 16'd7, 16'd0},
                 hold:1'b0, cc:32'd20, to:1'b1, h:4'h6};
      tbl[8] = '{mask:4'h1, lim:32'd1, ht:'0,
                 hold:1'b0, cc:32'd1, to:1'b1, h:4'h0};

      #1 rst_n = 1'b0;
      @(negedge clk);
      chk_all("reset", 4'hF, 1'b1, 1'b0, 4'h0, 32'd0, 1'b0);
      repeat (2) @(negedge clk);
      // A start on the first edge after release must be ignored.
      rst_n = 1'b1;
      start = 1'b1;
      mask  = 4'hF;
      @(negedge clk);
      chk("sync_edge1.idle", 32'(ap_idle), 32'd1);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk_all("post_sync", 4'hF, 1'b1, 1'b0, 4'h0, 32'd0, 1'b0);

      for (int k = 0; k < 9; k++) run(k, tbl[k]);

      for (int k = 0; k < 24; k++) begin
         v      = '0;
         v.mask = 4'($urandom);
         v.hold = 1'($urandom_range(0, 1));
         v.lim  = ($urandom_range(0, 2) == 0) ? 32'd0
                                              : 32'($urandom_range(1, 60));
         for (int i = 0; i < NC; i++)
            v.ht[i] = (v.lim != 0 && $urandom_range(0, 3) == 0)
                      ? 16'd0 : 16'($urandom_range(1, 60));
         run(100 + k, model(v));
      end
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);

      // Async reset mid-run with core 0 already halted.
      mask  = 4'hF;
      lim   = 32'd0;
      start = 1'b1;
      for (int i = 0; i < NC; i++) pc[i*PCW +: PCW] = pcv(1'b0);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      pc[0 +: PCW] = ENDPC;
      repeat (RSTC + 5) @(negedge clk);
      chk("midrun.pre_halted", 32'(halted), 32'h1);
      chk("midrun.pre_cycles", cycle_count, 32'd4);
      rst_n = 1'b0;
      #1;
      chk_all("midrun_rst", 4'hF, 1'b1, 1'b0, 4'h0, 32'd0, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk_all("midrun_after", 4'hF, 1'b1, 1'b0, 4'h0, 32'd0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
